// File: rtl/bitcell_word_ctrl_if.sv
// Request/response channel between an upstream master and the
// bitcell word controller.
interface bitcell_word_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/bitcell_word_ctrl.sv
// Word-level read/write sequencer for a DEPTH x WIDTH NAND-latch
// bitcell array with registered, glitch-free cell strobes.
module bitcell_word_ctrl #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 4,
  parameter int AW            = 2,
  parameter int STROBE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  bitcell_word_ctrl_if.slave bus,
  output logic [DEPTH-1:0] cell_sel,
  output logic             cell_rw,
  output logic [WIDTH-1:0] cell_din,
  input  logic [WIDTH-1:0] cell_dout,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, RESP
  } state_t;

  localparam int CW = $clog2(STROBE_CYCLES + 1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             we_q;
  logic             err_q;
  logic             in_range;
  logic [DEPTH-1:0] onehot;

  assign in_range = {1'b0, bus.req_addr} < DEPTH_W;

  always_comb begin
    onehot = '0;
    for (int i = 0; i < DEPTH; i++)
      if (bus.req_addr == AW'(i))
        onehot[i] = 1'b1;
  end

  assign bus.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      cell_sel      <= '0;
      cell_rw       <= 1'b0;
      cell_din      <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            err_q    <= !in_range;
            cell_sel <= in_range ? onehot : '0;
            cell_din <= bus.req_we ? bus.req_wdata : '0;
            cell_rw  <= 1'b0;
            cnt      <= CW'(STROBE_CYCLES - 1);
            state    <= SETUP;
          end
        end
        SETUP: begin
          // Out-of-range requests never raise r_w.
          cell_rw <= we_q && !err_q;
          state   <= STROBE;
        end
        STROBE: begin
          if (cnt == '0) begin
            cell_rw <= 1'b0;
            state   <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          cell_sel      <= '0;
          cell_din      <= '0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= err_q;
          bus.rsp_rdata <= (!we_q && !err_q) ? cell_dout : '0;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitcell_word_ctrl.sv
// Directed bench for bitcell_word_ctrl with a behavioural array
// model and a second DEPTH=3 instance for out-of-range addresses.
module tb_bitcell_word_ctrl;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AW = 2;
  localparam int S  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bitcell_word_ctrl_if #(.WIDTH(W), .AW(AW)) bus ();
  bitcell_word_ctrl_if #(.WIDTH(W), .AW(AW)) bus3 ();

  logic [D-1:0] cell_sel;
  logic         cell_rw;
  logic [W-1:0] cell_din;
  logic [W-1:0] cell_dout;
  logic         busy;

  logic [2:0]   sel3;
  logic         rw3;
  logic [W-1:0] din3;
  logic [W-1:0] dout3;
  logic         busy3;

  bitcell_word_ctrl #(
    .WIDTH(W), .DEPTH(D), .AW(AW), .STROBE_CYCLES(S)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .cell_sel(cell_sel), .cell_rw(cell_rw),
    .cell_din(cell_din), .cell_dout(cell_dout),
    .busy(busy)
  );

  bitcell_word_ctrl #(
    .WIDTH(W), .DEPTH(3), .AW(AW), .STROBE_CYCLES(S)
  ) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave),
    .cell_sel(sel3), .cell_rw(rw3),
    .cell_din(din3), .cell_dout(dout3),
    .busy(busy3)
  );

  assign dout3 = '0;

  // Array model: a selected row latches din while r_w is high.
  logic [W-1:0] mem [D];

  always @(negedge clk)
    if (cell_rw)
      for (int i = 0; i < D; i++)
        if (cell_sel[i]) mem[i] <= cell_din;

  always_comb begin
    cell_dout = '0;
    for (int i = 0; i < D; i++)
      if (cell_sel[i]) cell_dout = mem[i];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic we, logic [AW-1:0] addr,
                       logic [W-1:0] data);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    step();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_wdata = '0;
  endtask

  task automatic get_rsp(output logic [W-1:0] rd,
                         output logic er);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("rsp_seen", {31'd0, bus.rsp_valid}, 32'd1);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    step();
  endtask

  logic [W-1:0] rd;
  logic         er;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b1;
    bus3.req_valid = 1'b0;
    bus3.req_we    = 1'b0;
    bus3.req_addr  = '0;
    bus3.req_wdata = '0;
    bus3.rsp_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sel", {28'd0, cell_sel}, 32'd0);
    chk("rst_rw", {31'd0, cell_rw}, 32'd0);
    chk("rst_din", {24'd0, cell_din}, 32'd0);
    chk("rst_rvalid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
    chk("rst_err", {31'd0, bus.rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Write addr 2 = 0xA5, cycle by cycle
    issue(1'b1, 2'd2, 8'hA5);
    chk("w2_c1_sel", {28'd0, cell_sel}, 32'h4);
    chk("w2_c1_rw", {31'd0, cell_rw}, 32'd0);
    chk("w2_c1_din", {24'd0, cell_din}, 32'hA5);
    chk("w2_c1_ready", {31'd0, bus.req_ready}, 32'd0);
    step();
    chk("w2_c2_rw", {31'd0, cell_rw}, 32'd1);
    chk("w2_c2_sel", {28'd0, cell_sel}, 32'h4);
    step();
    chk("w2_c3_rw", {31'd0, cell_rw}, 32'd1);
    step();
    chk("w2_c4_rw", {31'd0, cell_rw}, 32'd0);
    chk("w2_c4_sel", {28'd0, cell_sel}, 32'h4);
    chk("w2_c4_valid", {31'd0, bus.rsp_valid}, 32'd0);
    step();
    chk("w2_c5_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("w2_c5_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("w2_c5_rdata", {24'd0, bus.rsp_rdata}, 32'h00);
    chk("w2_c5_sel", {28'd0, cell_sel}, 32'd0);
    step();
    chk("w2_c6_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("w2_c6_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("w2_c6_busy", {31'd0, busy}, 32'd0);

    // Read addr 2: r_w never rises
    issue(1'b0, 2'd2, 8'h00);
    chk("r2_c1_sel", {28'd0, cell_sel}, 32'h4);
    chk("r2_c1_din", {24'd0, cell_din}, 32'h00);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk("r2_rw_low", {31'd0, cell_rw}, 32'd0);
    end
    step();
    chk("r2_c5_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("r2_c5_rdata", {24'd0, bus.rsp_rdata}, 32'hA5);
    chk("r2_c5_err", {31'd0, bus.rsp_err}, 32'd0);
    step();

    // Row isolation
    issue(1'b1, 2'd1, 8'h3C);
    get_rsp(rd, er);
    issue(1'b1, 2'd0, 8'hFF);
    get_rsp(rd, er);
    issue(1'b0, 2'd1, 8'h00);
    get_rsp(rd, er);
    chk("r1_rdata", {24'd0, rd}, 32'h3C);
    chk("r1_err", {31'd0, er}, 32'd0);
    issue(1'b0, 2'd0, 8'h00);
    get_rsp(rd, er);
    chk("r0_rdata", {24'd0, rd}, 32'hFF);

    // Back-pressure on a read of addr 3
    issue(1'b1, 2'd3, 8'h5A);
    get_rsp(rd, er);
    bus.rsp_ready = 1'b0;
    issue(1'b0, 2'd3, 8'h00);
    step();
    step();
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_rdata", {24'd0, bus.rsp_rdata}, 32'h5A);
      chk("bp_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      if (i < 3) step();
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("bp_rel_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("bp_rel_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("bp_rel_busy", {31'd0, busy}, 32'd0);

    // Out-of-range on the DEPTH=3 instance
    bus3.req_valid = 1'b1;
    bus3.req_we    = 1'b1;
    bus3.req_addr  = 2'd3;
    bus3.req_wdata = 8'h77;
    step();
    bus3.req_valid = 1'b0;
    chk("oor_busy", {31'd0, busy3}, 32'd1);
    for (int c = 1; c <= 4; c++) begin
      chk("oor_sel", {29'd0, sel3}, 32'd0);
      chk("oor_rw", {31'd0, rw3}, 32'd0);
      step();
    end
    chk("oor_valid", {31'd0, bus3.rsp_valid}, 32'd1);
    chk("oor_err", {31'd0, bus3.rsp_err}, 32'd1);
    chk("oor_rdata", {24'd0, bus3.rsp_rdata}, 32'h00);
    step();
    chk("oor_idle", {31'd0, bus3.req_ready}, 32'd1);

    // Reset during STROBE of a write
    issue(1'b1, 2'd0, 8'h11);
    step();
    chk("rs_rw_pre", {31'd0, cell_rw}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_rw", {31'd0, cell_rw}, 32'd0);
    chk("rs_sel", {28'd0, cell_sel}, 32'd0);
    chk("rs_busy", {31'd0, busy}, 32'd0);
    chk("rs_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("rs_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    issue(1'b1, 2'd0, 8'h22);
    get_rsp(rd, er);
    chk("rs_w_err", {31'd0, er}, 32'd0);
    issue(1'b0, 2'd0, 8'h00);
    get_rsp(rd, er);
    chk("rs_r_rdata", {24'd0, rd}, 32'h22);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
